// File: rtl/fd_ldst_seq_pkg.sv
// Shared op codes and sequencer state encoding for the load/store datapath.
package fd_ldst_seq_pkg;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_MEMRD = 3'd2,
    S_WB    = 3'd3,
    S_MEMWR = 3'd4,
    S_FAULT = 3'd5
  } state_t;

endpackage

// File: rtl/fd_ldst_seq_if.sv
// Instruction issue / completion bus of fd_ldst_seq, plus memory preload and FSM state visibility.
interface fd_ldst_seq_if #(
  parameter int WIDTH = 64,
  parameter int RAW   = 5,
  parameter int MAW   = 5
);
  // start is taken only when busy=0; done pulses one cycle and err/result are valid with it.
  logic                          start;
  logic [1:0]                    op;
  logic [RAW-1:0]                ra;
  logic [RAW-1:0]                rb;
  logic [RAW-1:0]                rw;
  logic [WIDTH-1:0]              offset;
  logic                          init_we;
  logic [MAW-1:0]                init_addr;
  logic [WIDTH-1:0]              init_data;
  logic                          busy;
  logic                          done;
  logic                          err;
  logic [WIDTH-1:0]              result;
  fd_ldst_seq_pkg::state_t       state;

  modport master (
    output start, op, ra, rb, rw, offset, init_we, init_addr, init_data,
    input  busy, done, err, result, state
  );

  modport slave (
    input  start, op, ra, rb, rw, offset, init_we, init_addr, init_data,
    output busy, done, err, result, state
  );
endinterface

// File: rtl/fd_ldst_seq_regfile.sv
// Register file: two combinational read ports, one synchronous write port, x0 reads as zero.
module fd_regfile #(
  parameter int WIDTH     = 64,
  parameter int REG_DEPTH = 32,
  parameter int RAW       = $clog2(REG_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RAW-1:0]   raddr_a,
  input  logic [RAW-1:0]   raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             we,
  input  logic [RAW-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] regs [REG_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see the array before the edge, so a same-cycle write returns the old value.
  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/fd_ldst_seq.sv
// Multi-cycle LD/ST/ADD/SUB datapath: register file, data memory, ALU and sequencer FSM.
module fd_ldst_seq
  import fd_ldst_seq_pkg::*;
#(
  parameter  int WIDTH     = 64,
  parameter  int REG_DEPTH = 32,
  parameter  int MEM_DEPTH = 32,
  localparam int RAW       = $clog2(REG_DEPTH),
  localparam int MAW       = $clog2(MEM_DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  fd_ldst_seq_if.slave bus
);

  state_t           state;
  logic [1:0]       op_q;
  logic [RAW-1:0]   ra_q;
  logic [RAW-1:0]   rb_q;
  logic [RAW-1:0]   rw_q;
  logic [WIDTH-1:0] off_q;
  logic [MAW-1:0]   addr_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] alu;
  logic [WIDTH-1:0] addr;
  logic             addr_ok;
  logic             init_ok;
  logic             is_alu;

  logic [WIDTH-1:0] mem [MEM_DEPTH];

  fd_regfile #(
    .WIDTH     (WIDTH),
    .REG_DEPTH (REG_DEPTH),
    .RAW       (RAW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (ra_q),
    .raddr_b (rb_q),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .we      (state == S_WB),
    .waddr   (rw_q),
    .wdata   (result_q)
  );

  assign is_alu  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign alu     = (op_q == OP_SUB) ? (rd_a - rd_b) : (rd_a + rd_b);
  // Full-width address so a wrapped or large sum is caught rather than aliased.
  assign addr    = rd_b + off_q;
  assign addr_ok = addr < WIDTH'(MEM_DEPTH);
  assign init_ok = 32'(bus.init_addr) < MEM_DEPTH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_LD;
      ra_q     <= '0;
      rb_q     <= '0;
      rw_q     <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            ra_q   <= bus.ra;
            rb_q   <= bus.rb;
            rw_q   <= bus.rw;
            off_q  <= bus.offset;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_alu) begin
            result_q <= alu;
            done_q   <= 1'b1;
            state    <= S_WB;
          end else if (!addr_ok) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            state  <= S_FAULT;
          end else begin
            addr_q <= addr[MAW-1:0];
            if (op_q == OP_LD) begin
              state <= S_MEMRD;
            end else begin
              // Store data is captured here and reused as the memory write value.
              result_q <= rd_a;
              done_q   <= 1'b1;
              state    <= S_MEMWR;
            end
          end
        end
        S_MEMRD: begin
          result_q <= mem[addr_q];
          done_q   <= 1'b1;
          state    <= S_WB;
        end
        S_WB, S_MEMWR, S_FAULT: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Memory has no reset; an async reset forces IDLE first, so an in-flight store never lands.
  always_ff @(posedge clk) begin
    if (state == S_MEMWR) begin
      mem[addr_q] <= result_q;
    end else if ((state == S_IDLE) && !bus.start && bus.init_we && init_ok) begin
      mem[bus.init_addr] <= bus.init_data;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;
  assign bus.state  = state;

endmodule

// File: tb/tb_fd_ldst_seq.sv
// Directed bench for fd_ldst_seq: latency, data, wrap, bounds, busy-ignore and mid-instruction reset.
module tb_fd_ldst_seq;
  import fd_ldst_seq_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  fd_ldst_seq_if #(.WIDTH(64), .RAW(5), .MAW(5)) bus ();

  fd_ldst_seq #(
    .WIDTH     (64),
    .REG_DEPTH (32),
    .MEM_DEPTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input int a, input logic [63:0] d);
    @(negedge clk);
    bus.init_we   = 1'b1;
    bus.init_addr = 5'(a);
    bus.init_data = d;
    @(negedge clk);
    bus.init_we   = 1'b0;
  endtask

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
  endtask

  // Issue one instruction; lat counts edges from the start-sampling edge to the done cycle.
  task automatic run(input logic [1:0] o, input int a, input int b, input int w,
                     input logic [63:0] off, output int lat);
    wait_idle();
    bus.op     = o;
    bus.ra     = 5'(a);
    bus.rb     = 5'(b);
    bus.rw     = 5'(w);
    bus.offset = off;
    bus.start  = 1'b1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
      if (bus.done) break;
    end
    if (!bus.done) lat = 99;
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input int a, input int b,
                       input int w, input logic [63:0] off, input int exp_lat,
                       input logic [63:0] exp_res, input logic exp_err);
    int lat;
    run(o, a, b, w, off, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, bus.result, exp_res);
    chk({tag, "_err"}, 64'(bus.err), 64'(exp_err));
  endtask

  // Observe a register by copying it through the ALU into x31.
  task automatic rd_reg(input string tag, input int k, input logic [63:0] exp);
    do_op(tag, OP_ADD, k, 0, 31, 64'd0, 2, exp, 1'b0);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = OP_LD; bus.ra = '0; bus.rb = '0; bus.rw = '0;
    bus.offset = '0; bus.init_we = 1'b0; bus.init_addr = '0; bus.init_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_state", 64'(bus.state), 64'(S_IDLE));

    preload(15, 64'd100);
    preload(21, 64'd7);

    do_op("ld1", OP_LD, 0, 0, 5, 64'd15, 3, 64'd100, 1'b0);
    rd_reg("x5", 5, 64'd100);

    do_op("st1", OP_ST, 5, 0, 0, 64'd20, 2, 64'd100, 1'b0);
    do_op("ld2", OP_LD, 0, 0, 6, 64'd20, 3, 64'd100, 1'b0);
    rd_reg("x6", 6, 64'd100);

    do_op("add", OP_ADD, 5, 6, 7, 64'd0, 2, 64'd200, 1'b0);
    do_op("sub", OP_SUB, 5, 7, 8, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FF9C, 1'b0);
    rd_reg("x8", 8, 64'hFFFF_FFFF_FFFF_FF9C);

    do_op("ldx0", OP_LD, 0, 0, 0, 64'd15, 3, 64'd100, 1'b0);
    do_op("addx9", OP_ADD, 0, 0, 9, 64'd0, 2, 64'd0, 1'b0);
    rd_reg("x9", 9, 64'd0);

    // Top word of memory, then reach it from x5=100 with a wrapping offset of -69.
    do_op("st31", OP_ST, 7, 0, 0, 64'd31, 2, 64'd200, 1'b0);
    do_op("ldwrap", OP_LD, 0, 5, 14, 64'hFFFF_FFFF_FFFF_FFBB, 3, 64'd200, 1'b0);

    // First address past the end faults and keeps the previous result.
    do_op("ld32", OP_LD, 0, 0, 15, 64'd32, 2, 64'd200, 1'b1);
    rd_reg("x15", 15, 64'd0);

    // Fault with start and init_we pulsed during EXEC; both must be ignored.
    rd_reg("x7", 7, 64'd200);
    wait_idle();
    bus.op = OP_LD; bus.ra = 5'd0; bus.rb = 5'd0; bus.rw = 5'd10; bus.offset = 64'd40;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("flt_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.op = OP_ADD; bus.ra = 5'd5; bus.rb = 5'd5; bus.rw = 5'd12; bus.offset = 64'd0;
    bus.start = 1'b1;
    bus.init_we = 1'b1; bus.init_addr = 5'd21; bus.init_data = 64'd55;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.init_we = 1'b0;
    chk("flt_done", 64'(bus.done), 64'd1);
    chk("flt_err", 64'(bus.err), 64'd1);
    chk("flt_result", bus.result, 64'd200);
    @(posedge clk);
    #1;
    chk("flt_after_busy", 64'(bus.busy), 64'd0);
    chk("flt_after_done", 64'(bus.done), 64'd0);
    rd_reg("x10", 10, 64'd0);
    rd_reg("x12", 12, 64'd0);
    do_op("ld21", OP_LD, 0, 0, 13, 64'd21, 3, 64'd7, 1'b0);

    // Reset in the MEMRD cycle of LD x11,15(x0).
    wait_idle();
    bus.op = OP_LD; bus.ra = 5'd0; bus.rb = 5'd0; bus.rw = 5'd11; bus.offset = 64'd15;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_state_memrd", 64'(bus.state), 64'(S_MEMRD));
    rst = 1'b1;
    #1;
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_done", 64'(bus.done), 64'd0);
    chk("mrst_result", bus.result, 64'd0);
    chk("mrst_state", 64'(bus.state), 64'(S_IDLE));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_reg("x11_rst", 11, 64'd0);
    rd_reg("x7_rst", 7, 64'd0);
    do_op("ld_after", OP_LD, 0, 0, 11, 64'd15, 3, 64'd100, 1'b0);
    rd_reg("x11", 11, 64'd100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
